// File: rtl/pc_pkg.sv
// Shared types for the npc PC unit: next-PC select codes, sequencer states and the fixed instruction length.
package pc_pkg;

    typedef enum logic [2:0] {
        SEQ    = 3'd0,
        BRANCH = 3'd1,
        JAL    = 3'd2,
        JALR   = 3'd3,
        ECALL  = 3'd5,
        MRET   = 3'd6
    } pc_src_e;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } pc_state_e;

    localparam int ILEN_BYTES = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry; push+pop replaces the top.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, wr_idx;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(RAS_DEPTH));
    assign top   = empty ? '0 : mem_q[ptr_q];

    // A pop on an empty stack is dropped so a push in the same cycle behaves as a plain push.
    always_comb begin
        do_pop  = pop && !empty;
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        if (push && do_pop) begin
            wr_en = 1'b1;
        end else if (push) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q + PTR_W'(1);
            ptr_d  = ptr_q + PTR_W'(1);
            if (!full) count_d = count_q + CNT_W'(1);
        end else if (do_pop) begin
            ptr_d   = ptr_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            if (wr_en) mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner for the npc core: fetch handshake, next-PC selection at commit,
// misaligned-target trapping and return-address prediction checking.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h8000_0000,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    input  logic            cmt_valid,
    input  logic [2:0]      cmt_src,
    input  logic            cmt_taken,
    input  logic [XLEN-1:0] cmt_imm,
    input  logic [XLEN-1:0] cmt_alu,
    input  logic            cmt_is_call,
    input  logic            cmt_is_ret,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    output logic            exc_misalign,
    output logic [XLEN-1:0] exc_tval,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_mispred,
    output pc_state_e       dbg_state,
    output logic            dbg_ras_full
);

    // Fetch handshake: a request transfers on a cycle where if_valid && if_ready; if_valid
    // and if_pc are held steady from FETCH entry until that cycle.
    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            exc_misalign_q, exc_misalign_d;
    logic [XLEN-1:0] exc_tval_q, exc_tval_d;
    logic            ras_mispred_q, ras_mispred_d;

    logic [XLEN-1:0] seq_pc, target;
    logic            check_align, commit, misalign;
    logic            ras_push, ras_pop, ras_empty;

    always_comb begin
        seq_pc      = pc_q + XLEN'(ILEN_BYTES);
        target      = RESET_VEC;
        check_align = 1'b0;
        case (cmt_src)
            SEQ:    target = seq_pc;
            BRANCH: begin
                target      = cmt_taken ? pc_q + cmt_imm : seq_pc;
                check_align = cmt_taken;
            end
            JAL:    begin
                target      = pc_q + cmt_imm;
                check_align = 1'b1;
            end
            JALR:   begin
                target      = cmt_alu & ~{{(XLEN-1){1'b0}}, 1'b1};
                check_align = 1'b1;
            end
            ECALL:  target = csr_mtvec;
            MRET:   target = csr_mepc;
            default: target = RESET_VEC;
        endcase
    end

    assign commit   = (state_q == ST_EXEC) && cmt_valid;
    assign misalign = commit && check_align && (target[1:0] != 2'b00);
    // A trapping instruction never retires its call/return side effects.
    assign ras_push = commit && !misalign && cmt_is_call;
    assign ras_pop  = commit && !misalign && cmt_is_ret;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: if (if_ready) state_d = ST_EXEC;
            ST_EXEC:  if (cmt_valid) state_d = ST_FETCH;
            default:  state_d = ST_BOOT;
        endcase
        pc_d           = commit ? (misalign ? csr_mtvec : target) : pc_q;
        exc_misalign_d = misalign;
        exc_tval_d     = misalign ? target : '0;
        ras_mispred_d  = ras_pop && !ras_empty && (ras_top != target);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_BOOT;
            pc_q           <= RESET_VEC;
            exc_misalign_q <= 1'b0;
            exc_tval_q     <= '0;
            ras_mispred_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            exc_misalign_q <= exc_misalign_d;
            exc_tval_q     <= exc_tval_d;
            ras_mispred_q  <= ras_mispred_d;
        end
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (dbg_ras_full)
    );

    assign if_valid     = (state_q == ST_FETCH);
    assign if_pc        = pc_q;
    assign exc_misalign = exc_misalign_q;
    assign exc_tval     = exc_tval_q;
    assign ras_mispred  = ras_mispred_q;
    assign dbg_state    = state_q;

endmodule
